// File: rtl/mips_defs.sv
// Shared MIPS definitions: fetch FSM encoding, reset PC default and opcode constants.
package mips_defs;

   // Default address of the first instruction after reset.
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Fetch stage FSM: waiting on memory, or holding a fetched instruction.
   typedef enum logic [0:0] {
      StReq   = 1'b0,
      StValid = 1'b1
   } fetch_state_e;

   // Primary opcodes (instr[31:26]) shared with Controller and benches.
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection for the fetch stage: sequential, branch or jump target.
module pc_next (
   input  logic [31:0] pc,
   input  logic [25:0] instr_index,
   input  logic [31:0] signimm,
   input  logic        pcsrc,
   input  logic        jump,
   output logic [31:0] pcplus4,
   output logic [31:0] nextpc
);

   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic [31:0] target;

   // Jump overrides branch; all additions wrap mod 2^32 and the result is word aligned.
   always_comb begin
      pcplus4       = pc + 32'd4;
      branch_target = pcplus4 + (signimm << 2);
      jump_target   = {pcplus4[31:28], instr_index, 2'b00};
      if (jump) begin
         target = jump_target;
      end else if (pcsrc) begin
         target = branch_target;
      end else begin
         target = pcplus4;
      end
      nextpc = target & ~32'd3;
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, reads instruction memory over a req/ack
// handshake, latches the returned word and advances the PC when downstream consumes it.
module instr_fetch
   import mips_defs::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ack,
   input  logic        instr_ready,
   input  logic        pcsrc,
   input  logic        jump,
   input  logic [31:0] signimm,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [5:0]  op,
   output logic [5:0]  funct,
   output logic [31:0] pc,
   output logic [31:0] pcplus4
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   // Low for the cycle reset is released so the first request starts one cycle later.
   logic         started_q;
   logic [31:0]  nextpc;

   pc_next u_pc_next (
      .pc          (pc_q),
      .instr_index (instr_q[25:0]),
      .signimm     (signimm),
      .pcsrc       (pcsrc),
      .jump        (jump),
      .pcplus4     (pcplus4),
      .nextpc      (nextpc)
   );

   // Next-state logic: capture on ack in REQ, advance PC on consume in VALID.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      unique case (state_q)
         StReq: begin
            if (started_q && imem_ack) begin
               instr_d = imem_rdata;
               state_d = StValid;
            end
         end
         StValid: begin
            if (instr_ready) begin
               pc_d    = nextpc;
               state_d = StReq;
            end
         end
         default: state_d = StReq;
      endcase
   end

   // Output decode from registered state only.
   always_comb begin
      imem_req    = started_q && (state_q == StReq);
      instr_valid = (state_q == StValid);
      imem_addr   = {pc_q[31:2], 2'b00};
      instr       = instr_q;
      op          = instr_q[31:26];
      funct       = instr_q[5:0];
      pc          = pc_q;
   end

   // State registers with synchronous reset; reset wins over ack/ready.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StReq;
         pc_q      <= RESET_PC;
         instr_q   <= 32'h0000_0000;
         started_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         started_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by randomized fetches,
// compared against a simple PC/instruction reference model.
module tb_instr_fetch;
   import mips_defs::*;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ack;
   logic        instr_ready;
   logic        pcsrc;
   logic        jump;
   logic [31:0] signimm;
   logic        instr_valid;
   logic [31:0] instr;
   logic [5:0]  op;
   logic [5:0]  funct;
   logic [31:0] pc;
   logic [31:0] pcplus4;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   logic [31:0] exp_pc;
   logic [31:0] exp_instr;

   instr_fetch #(
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_ack    (imem_ack),
      .instr_ready (instr_ready),
      .pcsrc       (pcsrc),
      .jump        (jump),
      .signimm     (signimm),
      .instr_valid (instr_valid),
      .instr       (instr),
      .op          (op),
      .funct       (funct),
      .pc          (pc),
      .pcplus4     (pcplus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] model_next(input logic [31:0] cur_pc,
                                              input logic [31:0] cur_instr,
                                              input logic b, input logic j,
                                              input logic [31:0] imm);
      logic [31:0] seq;
      logic [31:0] t;
      seq = cur_pc + 32'd4;
      if (j)      t = (seq & 32'hF000_0000) | ((cur_instr & 32'h03FF_FFFF) * 32'd4);
      else if (b) t = seq + imm * 32'd4;
      else        t = seq;
      return t & 32'hFFFF_FFFC;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // From a negedge in REQ: hold off ack for 'waits' cycles, then return 'word'.
   task automatic fetch(input int waits, input logic [31:0] word);
      for (int i = 0; i < waits; i++) begin
         chk("wait_req", {31'd0, imem_req}, 32'd1);
         chk("wait_addr", imem_addr, exp_pc);
         chk("wait_valid", {31'd0, instr_valid}, 32'd0);
         imem_ack = 1'b0;
         step();
      end
      chk("req", {31'd0, imem_req}, 32'd1);
      chk("addr", imem_addr, exp_pc);
      imem_ack   = 1'b1;
      imem_rdata = word;
      step();
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      exp_instr  = word;
      chk("valid", {31'd0, instr_valid}, 32'd1);
      chk("req_low", {31'd0, imem_req}, 32'd0);
      chk("instr", instr, exp_instr);
      chk("op", {26'd0, op}, exp_instr >> 26);
      chk("funct", {26'd0, funct}, exp_instr & 32'h3F);
      chk("pc", pc, exp_pc);
      chk("pcplus4", pcplus4, exp_pc + 32'd4);
   endtask

   // From a negedge in VALID: stall, optionally with a stray ack, then consume.
   task automatic consume(input logic b, input logic j, input logic [31:0] imm,
                          input int stall, input logic stray);
      for (int i = 0; i < stall; i++) begin
         instr_ready = 1'b0;
         pcsrc       = 1'($urandom);
         jump        = 1'($urandom);
         signimm     = $urandom;
         imem_ack    = stray;
         imem_rdata  = $urandom;
         step();
         chk("stall_valid", {31'd0, instr_valid}, 32'd1);
         chk("stall_req", {31'd0, imem_req}, 32'd0);
         chk("stall_instr", instr, exp_instr);
         chk("stall_pc", pc, exp_pc);
      end
      imem_ack    = 1'b0;
      instr_ready = 1'b1;
      pcsrc       = b;
      jump        = j;
      signimm     = imm;
      step();
      instr_ready = 1'b0;
      pcsrc       = 1'b0;
      jump        = 1'b0;
      signimm     = 32'd0;
      exp_pc      = model_next(exp_pc, exp_instr, b, j, imm);
      chk("next_valid", {31'd0, instr_valid}, 32'd0);
      chk("next_req", {31'd0, imem_req}, 32'd1);
      chk("next_addr", imem_addr, exp_pc);
   endtask

   initial begin
      logic [31:0] imm;
      reset       = 1'b1;
      imem_ack    = 1'b0;
      imem_rdata  = 32'd0;
      instr_ready = 1'b0;
      pcsrc       = 1'b0;
      jump        = 1'b0;
      signimm     = 32'd0;
      exp_pc      = 32'h0000_0000;
      exp_instr   = 32'd0;

      // Reset state.
      step();
      step();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_op", {26'd0, op}, 32'd0);
      chk("rst_funct", {26'd0, funct}, 32'd0);
      chk("rst_pc", pc, 32'h0000_0000);
      reset = 1'b0;
      step();

      // Zero-wait first fetch of a lw.
      fetch(0, 32'h8C02_0004);
      chk("t1_op_lw", {26'd0, op}, {26'd0, OP_LW});
      chk("t1_funct", {26'd0, funct}, 32'd4);
      chk("t1_pcplus4", pcplus4, 32'd4);

      // Sequential fetches 4, 8, C at one per two cycles.
      consume(1'b0, 1'b0, 32'd0, 0, 1'b0);
      chk("t2_addr4", imem_addr, 32'h4);
      fetch(0, $urandom);
      consume(1'b0, 1'b0, 32'd0, 0, 1'b0);
      chk("t2_addr8", imem_addr, 32'h8);
      fetch(0, $urandom);
      consume(1'b0, 1'b0, 32'd0, 0, 1'b0);
      chk("t2_addrC", imem_addr, 32'hC);
      fetch(0, $urandom);

      // Branches: back to 8, then pc=8 with -2 and +3.
      consume(1'b1, 1'b0, 32'hFFFF_FFFE, 0, 1'b0);
      chk("t3_back8", imem_addr, 32'h8);
      fetch(0, $urandom);
      consume(1'b1, 1'b0, 32'hFFFF_FFFE, 0, 1'b0);
      chk("t3_neg", imem_addr, 32'h4);
      fetch(0, $urandom);
      consume(1'b0, 1'b0, 32'd0, 0, 1'b0);
      fetch(0, $urandom);
      consume(1'b1, 1'b0, 32'd3, 0, 1'b0);
      chk("t3_pos", imem_addr, 32'h18);
      fetch(0, $urandom);

      // Jump wins over branch from pc=1000_0000.
      imm = (32'h1000_0000 - (exp_pc + 32'd4)) >> 2;
      consume(1'b1, 1'b0, imm, 0, 1'b0);
      chk("t4_at", imem_addr, 32'h1000_0000);
      fetch(0, 32'h0800_0010);
      consume(1'b1, 1'b1, 32'h0000_0100, 0, 1'b0);
      chk("t4_jump", imem_addr, 32'h1000_0040);

      // Wait states, long stall with stray acks.
      fetch(3, $urandom);
      consume(1'b0, 1'b0, 32'd0, 5, 1'b1);

      // Wrap from FFFF_FFFC to 0.
      fetch(1, $urandom);
      imm = (32'hFFFF_FFFC - (exp_pc + 32'd4)) >> 2;
      consume(1'b1, 1'b0, imm, 0, 1'b0);
      chk("t6_top", imem_addr, 32'hFFFF_FFFC);
      fetch(0, $urandom);
      consume(1'b0, 1'b0, 32'd0, 0, 1'b0);
      chk("t6_wrap", imem_addr, 32'h0);
      fetch(0, $urandom);
      consume(1'b0, 1'b0, 32'd0, 0, 1'b0);

      // Reset in REQ coinciding with an ack: reset wins.
      reset      = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      step();
      reset    = 1'b0;
      imem_ack = 1'b0;
      exp_pc   = 32'h0000_0000;
      chk("t6_rst_pc", pc, 32'h0);
      chk("t6_rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("t6_rst_req", {31'd0, imem_req}, 32'd0);
      chk("t6_rst_instr", instr, 32'd0);
      step();
      fetch(0, $urandom);

      // Reset in VALID coinciding with instr_ready: reset wins.
      reset       = 1'b1;
      instr_ready = 1'b1;
      step();
      reset       = 1'b0;
      instr_ready = 1'b0;
      chk("rv_pc", pc, 32'h0);
      chk("rv_valid", {31'd0, instr_valid}, 32'd0);
      chk("rv_instr", instr, 32'd0);
      step();

      // Randomized fetch/consume sequence against the model.
      for (int n = 0; n < 40; n++) begin
         fetch(int'($urandom_range(0, 3)), $urandom);
         consume(1'($urandom), 1'($urandom), $urandom,
                 int'($urandom_range(0, 2)), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
